dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU memory stage and the VGA engine.
// One synchronous RAM port; CPU wins by default, VGA wins after starvation.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        vga_req,
    input  logic [16:0] vga_addr,
    output logic        vga_ack,
    output logic [31:0] vga_rdata,
    output logic [16:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    state_t      state, state_n;
    // owner: 0 = CPU, 1 = VGA
    logic        owner, owner_n;
    logic [1:0]  starve_cnt, starve_n;
    logic [16:0] addr_n;
    logic [31:0] data_n;
    logic        wren_n;
    logic        cpu_ack_n, vga_ack_n;
    logic [31:0] cpu_rdata_n, vga_rdata_n;

    logic cpu_elig, vga_elig, vga_win;

    assign cpu_elig  = cpu_req & ~cpu_ack;
    assign vga_elig  = vga_req & ~vga_ack;
    assign vga_win   = vga_elig & (~cpu_elig | (starve_cnt == LIMIT));
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        starve_n    = starve_cnt;
        addr_n      = address_dmem;
        data_n      = data;
        wren_n      = 1'b0;
        cpu_ack_n   = 1'b0;
        vga_ack_n   = 1'b0;
        cpu_rdata_n = cpu_rdata;
        vga_rdata_n = vga_rdata;
        unique case (state)
            IDLE: begin
                if (cpu_elig | vga_elig) begin
                    state_n = ISSUE;
                    owner_n = vga_win;
                    if (vga_win) begin
                        addr_n   = vga_addr;
                        starve_n = 2'd0;
                    end else begin
                        addr_n = cpu_addr;
                        wren_n = cpu_we;
                        if (cpu_we)
                            data_n = cpu_wdata;
                        if (vga_elig && starve_cnt != LIMIT)
                            starve_n = starve_cnt + 2'd1;
                    end
                end
            end
            ISSUE: begin
                // wren high here means a CPU write is in flight
                if (wren) begin
                    state_n   = IDLE;
                    cpu_ack_n = 1'b1;
                end else begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                state_n = IDLE;
                if (owner) begin
                    vga_ack_n   = 1'b1;
                    vga_rdata_n = q_dmem;
                end else begin
                    cpu_ack_n   = 1'b1;
                    cpu_rdata_n = q_dmem;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            starve_cnt   <= 2'd0;
            address_dmem <= 17'd0;
            data         <= 32'd0;
            wren         <= 1'b0;
            cpu_ack      <= 1'b0;
            vga_ack      <= 1'b0;
            cpu_rdata    <= 32'd0;
            vga_rdata    <= 32'd0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            starve_cnt   <= starve_n;
            address_dmem <= addr_n;
            data         <= data_n;
            wren         <= wren_n;
            cpu_ack      <= cpu_ack_n;
            vga_ack      <= vga_ack_n;
            cpu_rdata    <= cpu_rdata_n;
            vga_rdata    <= vga_rdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural RAM.
// CPU uses addresses 0..0xFF, VGA reads 0x100 and above.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        vga_req;
    logic [16:0] vga_addr = '0;
    logic        vga_ack;
    logic [31:0] vga_rdata;
    logic [16:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem = '0;

    logic cpu_req_drv = 1'b0;
    logic vga_req_drv = 1'b0;
    logic mask = 1'b0;

    assign cpu_req = cpu_req_drv & ~(mask & vga_ack);
    assign vga_req = vga_req_drv & ~(mask & cpu_ack);

    always #5 clock = ~clock;

    dmem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem)
    );

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [31:0] d;
        int          cyc;
        bit          exact;
    } ent_t;

    ent_t cq[$];
    ent_t vq[$];
    int   order[$];
    ent_t me, mv;

    logic [31:0] ram [0:131071];
    logic [31:0] model_mem [0:131071];

    int total = 0, bad = 0, cyc = 0;
    int wren_cnt = 0, cpu_acks = 0, vga_acks = 0;
    int last_cpu = -1, last_vga = -1;

    function automatic logic [31:0] init_val(int a);
        return 32'(a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function void chk(string n, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endfunction

    function void fail_now(string n);
        total++;
        bad++;
        $display("FAIL %s", n);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        q_dmem <= ram[address_dmem];
        if (wren) ram[address_dmem] <= data;
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
            if (cpu_ack && vga_ack) fail_now("both_ack");
            if (wren) begin
                wren_cnt++;
                if (cq.size() == 0 || !cq[0].we) begin
                    fail_now("wren_unexpected");
                end else begin
                    chk("wr_addr", 32'(address_dmem), 32'(cq[0].addr));
                    chk("wr_data", data, cq[0].d);
                end
            end
            if (cpu_ack) begin
                cpu_acks++;
                last_cpu = cyc;
                order.push_back(0);
                if (cq.size() == 0) begin
                    fail_now("cpu_ack_spurious");
                end else begin
                    me = cq.pop_front();
                    if (!me.we) chk("cpu_rdata", cpu_rdata, me.d);
                    if (me.exact)
                        chk("cpu_lat", 32'(cyc - me.cyc), me.we ? 32'd2 : 32'd3);
                end
            end
            if (vga_ack) begin
                vga_acks++;
                last_vga = cyc;
                order.push_back(1);
                if (vq.size() == 0) begin
                    fail_now("vga_ack_spurious");
                end else begin
                    mv = vq.pop_front();
                    chk("vga_rdata", vga_rdata, mv.d);
                    if (mv.exact) chk("vga_lat", 32'(cyc - mv.cyc), 32'd3);
                end
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cpu_do(input logic we, input logic [16:0] a,
                          input logic [31:0] wd, input bit exact);
        ent_t e;
        bit got = 0;
        e.we = we;
        e.addr = a;
        e.d = we ? wd : model_mem[a];
        e.cyc = cyc;
        e.exact = exact;
        cq.push_back(e);
        if (we) model_mem[a] = wd;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        cpu_req_drv = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (cpu_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("cpu_timeout");
        cpu_req_drv = 1'b0;
    endtask

    task automatic vga_do(input logic [16:0] a, input bit exact);
        ent_t e;
        bit got = 0;
        e.we = 1'b0;
        e.addr = a;
        e.d = model_mem[a];
        e.cyc = cyc;
        e.exact = exact;
        vq.push_back(e);
        vga_addr = a;
        vga_req_drv = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (vga_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("vga_timeout");
        vga_req_drv = 1'b0;
    endtask

    initial begin
        int c0, w0, rel;
        bit got;
        ent_t e;
        for (int i = 0; i < 131072; i++) begin
            ram[i] = init_val(i);
            model_mem[i] = init_val(i);
        end

        // requests present during reset must not start anything
        cpu_req_drv = 1'b1;
        cpu_we = 1'b1;
        cpu_wdata = 32'h12345678;
        vga_req_drv = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_vga_ack", 32'(vga_ack), 32'd0);
        chk("rst_addr", 32'(address_dmem), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_vga_rdata", vga_rdata, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        cpu_req_drv = 1'b0;
        vga_req_drv = 1'b0;
        cpu_we = 1'b0;
        gap(1);
        reset = 1'b1;
        gap(2);

        // single CPU write then read-back
        w0 = wren_cnt;
        cpu_do(1'b1, 17'h00010, 32'hDEADBEEF, 1'b1);
        gap(1);
        chk("wr_wren_cycles", 32'(wren_cnt - w0), 32'd1);
        w0 = wren_cnt;
        cpu_do(1'b0, 17'h00010, 32'h0, 1'b1);
        gap(1);
        chk("rd_value", cpu_rdata, 32'hDEADBEEF);
        chk("rd_no_wren", 32'(wren_cnt - w0), 32'd0);

        // VGA alone at the top address
        c0 = cpu_acks;
        vga_do(17'h1FFFF, 1'b1);
        gap(1);
        chk("vga_only_no_cpu", 32'(cpu_acks - c0), 32'd0);

        // handoff in the CPU ack cycle
        c0 = cpu_acks;
        fork
            cpu_do(1'b0, 17'h00020, 32'h0, 1'b0);
            vga_do(17'h00300, 1'b0);
        join
        gap(1);
        chk("handoff_lat", 32'(last_vga - last_cpu), 32'd3);
        chk("handoff_cpu_once", 32'(cpu_acks - c0), 32'd1);

        // starvation: both requesters contend at every arbitration
        gap(1);
        mask = 1'b1;
        order.delete();
        fork
            for (int i = 0; i < 9; i++)
                cpu_do(1'b0, 17'(i), 32'h0, 1'b0);
            for (int j = 0; j < 3; j++)
                vga_do(17'(32'h400 + j), 1'b0);
        join
        mask = 1'b0;
        gap(1);
        chk("starve_len", 32'(order.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            if (k < order.size())
                chk($sformatf("starve_grant%0d", k),
                    32'(order[k]), (k % 4 == 3) ? 32'd1 : 32'd0);

        // reset asserted while a CPU write is in ISSUE
        gap(1);
        e.we = 1'b1;
        e.addr = 17'h00040;
        e.d = 32'hCAFE0040;
        e.cyc = cyc;
        e.exact = 1'b0;
        cq.push_back(e);
        model_mem[17'h00040] = 32'hCAFE0040;
        cpu_we = 1'b1;
        cpu_addr = 17'h00040;
        cpu_wdata = 32'hCAFE0040;
        cpu_req_drv = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_wren_before", 32'(wren), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_wren_drop", 32'(wren), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("mid_no_ack", 32'(cpu_ack), 32'd0);
        end
        reset = 1'b1;
        rel = cyc;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (cpu_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("mid_timeout");
        else chk("mid_rearb_lat", 32'(cyc - rel), 32'd2);
        cpu_req_drv = 1'b0;
        gap(2);

        // random traffic on both ports
        fork
            repeat (40) begin
                gap($urandom_range(0, 3));
                cpu_do(1'($urandom_range(0, 1)),
                       17'($urandom_range(0, 255)),
                       $urandom, 1'b0);
            end
            repeat (30) begin
                gap($urandom_range(0, 4));
                vga_do(17'($urandom_range(256, 131071)), 1'b0);
            end
        join
        gap(4);
        chk("cpu_q_empty", 32'(cq.size()), 32'd0);
        chk("vga_q_empty", 32'(vq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
